// File: rtl/mul_div_ctrl_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
interface mul_div_ctrl_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic [2:0]      req_op;
  logic            req_word;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            flush;
  logic            resp_ready;
  logic            req_ready;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  logic            stall;

  modport master (
    output req_valid, req_op, req_word, req_a, req_b, flush, resp_ready,
    input  req_ready, resp_valid, resp_data, stall
  );

  modport slave (
    input  req_valid, req_op, req_word, req_a, req_b, flush, resp_ready,
    output req_ready, resp_valid, resp_data, stall
  );
endinterface

// File: rtl/mul_div_ctrl.sv
// Iterative RV64 M-extension unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with the sign fixed up on the final iteration.
module mul_div_ctrl #(
  parameter int XLEN = 64
) (
  input logic           clk,
  input logic           reset,
  mul_div_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateType;
  stateType state, stateNext;

  logic [6:0]        count;
  logic [2:0]        opReg;
  logic              wordReg, negRes, negRem;
  logic [2*XLEN-1:0] acc, mcand;
  logic [XLEN-1:0]   mplr, rem, quo, divisor, resData;

  logic              accept, isDiv, aSigned, bSigned, aNeg, bNeg, bZero;
  logic [XLEN-1:0]   aExt, bExt, aMag, bMag, zeroDivRes;

  logic [2*XLEN-1:0] accNext, product;
  logic [XLEN:0]     remShift;
  logic              remFits;
  logic [XLEN-1:0]   remNext, quoNext, quotient, remainder, rawResult, finalResult;

  // Word mode narrows operands to 32 bits; a word multiply is MULW whatever the op says,
  // so its operands are taken unsigned (only the low product half is kept).
  always_comb begin
    isDiv = bus.req_op[2];
    if (isDiv) begin
      aSigned = ~bus.req_op[0];
      bSigned = ~bus.req_op[0];
    end else if (bus.req_word) begin
      aSigned = 1'b0;
      bSigned = 1'b0;
    end else begin
      aSigned = (bus.req_op[1:0] == 2'b01) || (bus.req_op[1:0] == 2'b10);
      bSigned = (bus.req_op[1:0] == 2'b01);
    end
    if (bus.req_word) begin
      aExt = {{(XLEN-32){aSigned & bus.req_a[31]}}, bus.req_a[31:0]};
      bExt = {{(XLEN-32){bSigned & bus.req_b[31]}}, bus.req_b[31:0]};
    end else begin
      aExt = bus.req_a;
      bExt = bus.req_b;
    end
    aNeg  = aSigned & aExt[XLEN-1];
    bNeg  = bSigned & bExt[XLEN-1];
    aMag  = aNeg ? -aExt : aExt;
    bMag  = bNeg ? -bExt : bExt;
    bZero = (bExt == '0);
    zeroDivRes = bus.req_op[1] ? aExt : '1;
    if (bus.req_word) zeroDivRes = {{(XLEN-32){zeroDivRes[31]}}, zeroDivRes[31:0]};
  end

  // One multiply step and one restoring-divide step, plus the signed result they lead to
  // so the last iteration can register the finished answer directly.
  always_comb begin
    accNext   = mplr[0] ? acc + mcand : acc;
    remShift  = {rem, quo[XLEN-1]};
    remFits   = remShift >= {1'b0, divisor};
    remNext   = remFits ? remShift[XLEN-1:0] - divisor : remShift[XLEN-1:0];
    quoNext   = {quo[XLEN-2:0], remFits};
    product   = negRes ? -accNext : accNext;
    quotient  = negRes ? -quoNext : quoNext;
    remainder = negRem ? -remNext : remNext;
    if (state == DIV) rawResult = opReg[1] ? remainder : quotient;
    else if ((opReg[1:0] == 2'b00) || wordReg) rawResult = product[XLEN-1:0];
    else rawResult = product[2*XLEN-1:XLEN];
    finalResult = wordReg ? {{(XLEN-32){rawResult[31]}}, rawResult[31:0]} : rawResult;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    if (bus.flush) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          accept    = 1'b1;
          stateNext = !isDiv ? MUL : (bZero ? DONE : DIV);
        end
        MUL, DIV: if (count == 7'd1) stateNext = DONE;
        DONE: if (bus.resp_ready) stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Word-mode dividends are left-aligned so the top quotient bit is always quo[XLEN-1].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      opReg   <= '0;
      wordReg <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      resData <= '0;
    end else if (bus.flush) begin
      count <= '0;
    end else if (accept) begin
      opReg   <= bus.req_op;
      wordReg <= bus.req_word;
      negRes  <= aNeg ^ bNeg;
      negRem  <= aNeg;
      acc     <= '0;
      mcand   <= {{XLEN{1'b0}}, aMag};
      mplr    <= bMag;
      rem     <= '0;
      quo     <= bus.req_word ? (aMag << 32) : aMag;
      divisor <= bMag;
      if (isDiv && bZero) begin
        count   <= '0;
        resData <= zeroDivRes;
      end else begin
        count <= bus.req_word ? 7'd32 : 7'd64;
      end
    end else if ((state == MUL) || (state == DIV)) begin
      acc   <= accNext;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      rem   <= remNext;
      quo   <= quoNext;
      count <= count - 7'd1;
      if (count == 7'd1) resData <= finalResult;
    end
  end

  assign bus.req_ready  = reset & (state == IDLE);
  assign bus.resp_valid = (state == DONE);
  assign bus.resp_data  = (state == DONE) ? resData : '0;
  assign bus.stall      = reset & ((bus.req_valid & (state != DONE)) |
                                   ((state == DONE) & ~bus.resp_ready));
endmodule
